// File: rtl/tl_pkg.sv
// Shared TileLink A-channel definitions.
// Holds the A-channel opcode encoding, the fixed field widths of the
// opcode/param/size fields and the default address/data/source widths
// used by the A-channel queue and its storage.
package tl_pkg;

  // TileLink A-channel opcodes
  typedef enum logic [2:0] {
    TL_A_PUT_FULL      = 3'd0,
    TL_A_PUT_PARTIAL   = 3'd1,
    TL_A_ARITHMETIC    = 3'd2,
    TL_A_LOGICAL       = 3'd3,
    TL_A_GET           = 3'd4,
    TL_A_INTENT        = 3'd5,
    TL_A_ACQUIRE_BLOCK = 3'd6,
    TL_A_ACQUIRE_PERM  = 3'd7
  } tl_a_opcode_e;

  localparam int TL_OPCODE_W     = 3;
  localparam int TL_PARAM_W      = 3;
  localparam int TL_SIZE_W       = 4;

  localparam int TL_DEF_ADDR_W   = 33;
  localparam int TL_DEF_DATA_W   = 64;
  localparam int TL_DEF_SOURCE_W = 5;

  // Width of one packed queue entry for the given field widths
  function automatic int tl_a_entry_w(input int addr_w, input int data_w,
                                      input int source_w, input int corrupt_w);
    return TL_OPCODE_W + TL_PARAM_W + TL_SIZE_W + source_w + addr_w + data_w + corrupt_w;
  endfunction

endpackage

// File: rtl/tl_queue_mem.sv
// Flop-based storage for the A-channel queue.
// DEPTH x WIDTH array, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clock   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write slot
//   wdata_i : write entry
//   raddr_i : read slot
//   rdata_o : entry at raddr_i (combinational)
module tl_queue_mem import tl_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: overwrite only the addressed slot
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_a_queue.sv
// TileLink A-channel ready/valid queue.
// DEPTH-entry FIFO with optional empty-queue bypass (FLOW) and
// accept-while-full-if-draining (PIPE). Head entry is presented
// combinationally from the storage array.
// Optional macro TL_A_QUEUE_CORRUPT_EN adds the io_enq_bits_corrupt
// input and stores it per entry; without it io_deq_bits_corrupt is 0.
//   clock, reset_n      : clock, asynchronous active-low reset
//   io_enq_*            : producer side (ready/valid + A-channel fields)
//   io_deq_*            : consumer side (ready/valid + A-channel fields)
//   io_count            : current occupancy
module tl_a_queue import tl_pkg::*; #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = TL_DEF_ADDR_W,
  parameter int DATA_W   = TL_DEF_DATA_W,
  parameter int SOURCE_W = TL_DEF_SOURCE_W,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   io_enq_ready,
  input  logic                   io_enq_valid,
  input  logic [TL_OPCODE_W-1:0] io_enq_bits_opcode,
  input  logic [TL_PARAM_W-1:0]  io_enq_bits_param,
  input  logic [TL_SIZE_W-1:0]   io_enq_bits_size,
  input  logic [SOURCE_W-1:0]    io_enq_bits_source,
  input  logic [ADDR_W-1:0]      io_enq_bits_address,
  input  logic [DATA_W-1:0]      io_enq_bits_data,
`ifdef TL_A_QUEUE_CORRUPT_EN
  input  logic                   io_enq_bits_corrupt,
`endif
  input  logic                   io_deq_ready,
  output logic                   io_deq_valid,
  output logic [TL_OPCODE_W-1:0] io_deq_bits_opcode,
  output logic [TL_PARAM_W-1:0]  io_deq_bits_param,
  output logic [TL_SIZE_W-1:0]   io_deq_bits_size,
  output logic [SOURCE_W-1:0]    io_deq_bits_source,
  output logic [ADDR_W-1:0]      io_deq_bits_address,
  output logic [DATA_W-1:0]      io_deq_bits_data,
  output logic                   io_deq_bits_corrupt,
  output logic [CNT_W-1:0]       io_count
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef TL_A_QUEUE_CORRUPT_EN
  localparam int CORR_W = 1;
`else
  localparam int CORR_W = 0;
`endif
  localparam int ENTRY_W = tl_a_entry_w(ADDR_W, DATA_W, SOURCE_W, CORR_W);

  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic               maybe_full_q, maybe_full_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               ptr_match_s, empty_s, full_s, bypass_s;
  logic               do_enq_s, do_deq_s;
  logic [ENTRY_W-1:0] wr_entry_s, rd_entry_s, deq_entry_s;

  assign ptr_match_s = (wptr_q == rptr_q);
  assign empty_s     = ptr_match_s & ~maybe_full_q;
  assign full_s      = ptr_match_s & maybe_full_q;
  assign bypass_s    = (FLOW != 32'sd0) & empty_s;

  assign io_enq_ready = (PIPE != 32'sd0) ? (~full_s | io_deq_ready) : ~full_s;
  assign io_deq_valid = (FLOW != 32'sd0) ? (~empty_s | io_enq_valid) : ~empty_s;

  // A bypassed beat goes straight through: no write, no read-pointer move
  assign do_enq_s = io_enq_valid & io_enq_ready & ~(bypass_s & io_deq_ready);
  assign do_deq_s = io_deq_valid & io_deq_ready & ~bypass_s;

`ifdef TL_A_QUEUE_CORRUPT_EN
  assign wr_entry_s = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
                       io_enq_bits_source, io_enq_bits_address, io_enq_bits_data,
                       io_enq_bits_corrupt};
`else
  assign wr_entry_s = {io_enq_bits_opcode, io_enq_bits_param, io_enq_bits_size,
                       io_enq_bits_source, io_enq_bits_address, io_enq_bits_data};
`endif

  tl_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clock   (clock),
    .we_i    (do_enq_s),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry_s)
  );

  // Head selection: producer fields while bypassing, else stored head
  always_comb begin
    deq_entry_s = rd_entry_s;
    if (bypass_s) begin
      deq_entry_s = wr_entry_s;
    end else begin
      deq_entry_s = rd_entry_s;
    end
  end

  assign {io_deq_bits_opcode, io_deq_bits_param, io_deq_bits_size,
          io_deq_bits_source, io_deq_bits_address, io_deq_bits_data} =
         deq_entry_s[ENTRY_W-1:CORR_W];

`ifdef TL_A_QUEUE_CORRUPT_EN
  assign io_deq_bits_corrupt = deq_entry_s[0];
`else
  assign io_deq_bits_corrupt = 1'b0;
`endif

  assign io_count = count_q;

  // Next-state: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    maybe_full_d = maybe_full_q;
    count_d      = count_q;
    if (do_enq_s) begin
      wptr_d = wptr_q + PTR_W'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_deq_s) begin
      rptr_d = rptr_q + PTR_W'(1'b1);
    end else begin
      rptr_d = rptr_q;
    end
    if (do_enq_s && !do_deq_s) begin
      maybe_full_d = 1'b1;
      count_d      = count_q + CNT_W'(1'b1);
    end else if (!do_enq_s && do_deq_s) begin
      maybe_full_d = 1'b0;
      count_d      = count_q - CNT_W'(1'b1);
    end else begin
      maybe_full_d = maybe_full_q;
      count_d      = count_q;
    end
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= {PTR_W{1'b0}};
      rptr_q       <= {PTR_W{1'b0}};
      maybe_full_q <= 1'b0;
      count_q      <= {CNT_W{1'b0}};
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      maybe_full_q <= maybe_full_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_tl_a_queue.sv
// Scoreboard bench for tl_a_queue: four instances
//   0: DEPTH=4, 1: DEPTH=2 FLOW=1, 2: DEPTH=2 PIPE=1, 3: DEPTH=8.
// Stimulus pushes expected beats; a negedge monitor pops and compares
// every dequeue handshake. Honours TL_A_QUEUE_CORRUPT_EN.
module tb_tl_a_queue;

`ifdef TL_A_QUEUE_CORRUPT_EN
  localparam logic CORRUPT_ON = 1'b1;
`else
  localparam logic CORRUPT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic [3:0]   enq_valid, enq_corrupt, deq_ready;
  logic [63:0]  enq_data [4];
  logic [3:0]   enq_ready, deq_valid;
  logic [112:0] deq_bits [4];
  logic [3:0]   cnt [4];

  int checks = 0;
  int errors = 0;

  logic [64:0] exp0[$], exp1[$], exp2[$], exp3[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 4 : ((g == 3) ? 8 : 2);
    localparam int CW  = $clog2(DEP + 1);
    logic [2:0]    op_o, par_o;
    logic [3:0]    sz_o;
    logic [4:0]    src_o;
    logic [32:0]   adr_o;
    logic [63:0]   dat_o;
    logic          cor_o;
    logic [CW-1:0] cnt_o;

    tl_a_queue #(
      .DEPTH (DEP),
      .FLOW  ((g == 1) ? 1 : 0),
      .PIPE  ((g == 2) ? 1 : 0)
    ) u_dut (
      .clock               (clk),
      .reset_n             (rst_n),
      .io_enq_ready        (enq_ready[g]),
      .io_enq_valid        (enq_valid[g]),
      .io_enq_bits_opcode  (enq_data[g][2:0]),
      .io_enq_bits_param   (enq_data[g][5:3]),
      .io_enq_bits_size    (enq_data[g][9:6]),
      .io_enq_bits_source  (enq_data[g][14:10]),
      .io_enq_bits_address ({enq_data[g][31:0], 1'b1}),
      .io_enq_bits_data    (enq_data[g]),
`ifdef TL_A_QUEUE_CORRUPT_EN
      .io_enq_bits_corrupt (enq_corrupt[g]),
`endif
      .io_deq_ready        (deq_ready[g]),
      .io_deq_valid        (deq_valid[g]),
      .io_deq_bits_opcode  (op_o),
      .io_deq_bits_param   (par_o),
      .io_deq_bits_size    (sz_o),
      .io_deq_bits_source  (src_o),
      .io_deq_bits_address (adr_o),
      .io_deq_bits_data    (dat_o),
      .io_deq_bits_corrupt (cor_o),
      .io_count            (cnt_o)
    );

    assign deq_bits[g] = {op_o, par_o, sz_o, src_o, adr_o, dat_o, cor_o};
    assign cnt[g]      = 4'(cnt_o);
  end

  // Expected dequeue fields for a stored {corrupt, data} beat
  function automatic logic [112:0] exp_bits(input logic [64:0] e);
    logic [63:0] d;
    d = e[63:0];
    return {d[2:0], d[5:3], d[9:6], d[14:10], d[31:0], 1'b1, d, e[64]};
  endfunction

  task automatic sb_push(input int k, input logic [64:0] v);
    case (k)
      0: exp0.push_back(v);
      1: exp1.push_back(v);
      2: exp2.push_back(v);
      default: exp3.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int k, output logic [64:0] v, output bit ok);
    ok = 1'b1;
    v  = '0;
    case (k)
      0: if (exp0.size() > 0) v = exp0.pop_front(); else ok = 1'b0;
      1: if (exp1.size() > 0) v = exp1.pop_front(); else ok = 1'b0;
      2: if (exp2.size() > 0) v = exp2.pop_front(); else ok = 1'b0;
      default: if (exp3.size() > 0) v = exp3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0: return exp0.size();
      1: return exp1.size();
      2: return exp2.size();
      default: return exp3.size();
    endcase
  endfunction

  task automatic chk(input string name, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, k, got, exp);
    end
  endtask

  // Drive one instance's inputs; optionally record the beat as expected
  task automatic drive(input int k, input logic ev, input logic [63:0] d,
                       input logic c, input logic dr, input bit push);
    enq_valid[k]   = ev;
    enq_data[k]    = d;
    enq_corrupt[k] = c;
    deq_ready[k]   = dr;
    if (push) sb_push(k, {enq_corrupt[k] & CORRUPT_ON, d});
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every dequeue handshake must match the head expectation
  always @(negedge clk) begin
    logic [64:0] e;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      if (rst_n && deq_valid[k] && deq_ready[k]) begin
        sb_pop(k, e, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sb_unexpected[%0d]: got %h expected no beat", k, deq_bits[k]);
        end else if (deq_bits[k] !== exp_bits(e)) begin
          errors++;
          $display("FAIL sb_beat[%0d]: got %h expected %h", k, deq_bits[k], exp_bits(e));
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    enq_valid   = 4'b0000;
    enq_corrupt = 4'b0000;
    deq_ready   = 4'b0000;
    for (int k = 0; k < 4; k++) enq_data[k] = 64'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_enq_ready", k, int'(enq_ready[k]), 1);
      chk("rst_deq_valid", k, int'(deq_valid[k]), 0);
      chk("rst_count", k, int'(cnt[k]), 0);
    end
    next_cyc();
    rst_n = 1'b1;

    // DEPTH=4: fill, refuse fifth, drain in order
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, 64'(i), i[0], 1'b0, 1'b1);
      next_cyc();
    end
    drive(0, 1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 0, int'(cnt[0]), 4);
    chk("full_enq_ready", 0, int'(enq_ready[0]), 0);
    chk("full_head", 0, int'(deq_bits[0][32:1]), 1);
    next_cyc();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drain_count", 0, int'(cnt[0]), 4 - j);
      if (j == 0) chk("full_nopipe_ready", 0, int'(enq_ready[0]), 0);
      next_cyc();
    end
    drive(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drained_count", 0, int'(cnt[0]), 0);
    chk("drained_valid", 0, int'(deq_valid[0]), 0);
    next_cyc();

    // FLOW=1: empty bypass, then ordinary queued traffic
    drive(1, 1'b1, 64'hAB, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("flow_valid", 1, int'(deq_valid[1]), 1);
    chk("flow_count", 1, int'(cnt[1]), 0);
    next_cyc();
    drive(1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flow_after_count", 1, int'(cnt[1]), 0);
    chk("flow_after_valid", 1, int'(deq_valid[1]), 0);
    next_cyc();
    drive(1, 1'b1, 64'h11, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(1, 1'b1, 64'h22, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("flow_q_count", 1, int'(cnt[1]), 1);
    next_cyc();
    drive(1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flow_q_count2", 1, int'(cnt[1]), 1);
    next_cyc();
    drive(1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flow_q_empty", 1, int'(cnt[1]), 0);
    next_cyc();

    // PIPE=1: full queue accepts while draining
    drive(2, 1'b1, 64'hA1, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(2, 1'b1, 64'hA2, 1'b1, 1'b0, 1'b1);
    next_cyc();
    drive(2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pipe_full_count", 2, int'(cnt[2]), 2);
    chk("pipe_full_ready", 2, int'(enq_ready[2]), 0);
    next_cyc();
    drive(2, 1'b1, 64'hCC, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("pipe_ready", 2, int'(enq_ready[2]), 1);
    next_cyc();
    drive(2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pipe_count", 2, int'(cnt[2]), 2);
    next_cyc();
    drive(2, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    repeat (2) next_cyc();
    drive(2, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pipe_empty", 2, int'(cnt[2]), 0);
    next_cyc();

    // DEPTH=8: 20 simultaneous enq/deq beats wrap pointers twice
    drive(3, 1'b1, 64'h100, 1'b0, 1'b0, 1'b1);
    next_cyc();
    for (int i = 0; i < 20; i++) begin
      drive(3, 1'b1, 64'h200 + 64'(i), i[1], 1'b1, 1'b1);
      @(negedge clk);
      chk("stream_count", 3, int'(cnt[3]), 1);
      next_cyc();
    end
    drive(3, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    next_cyc();
    drive(3, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_empty", 3, int'(cnt[3]), 0);
    next_cyc();

    // Mid-cycle reset with three entries held
    drive(0, 1'b1, 64'h31, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(0, 1'b1, 64'h32, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(0, 1'b1, 64'h33, 1'b0, 1'b0, 1'b1);
    next_cyc();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("prerst_count", 0, int'(cnt[0]), 3);
    #1;
    rst_n = 1'b0;
    exp0.delete();
    #1;
    chk("midrst_count", 0, int'(cnt[0]), 0);
    chk("midrst_valid", 0, int'(deq_valid[0]), 0);
    chk("midrst_ready", 0, int'(enq_ready[0]), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    next_cyc();
    drive(0, 1'b1, 64'h41, 1'b1, 1'b0, 1'b1);
    next_cyc();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("postrst_count", 0, int'(cnt[0]), 1);
    next_cyc();
    drive(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_empty", 0, int'(cnt[0]), 0);
    next_cyc();

    // Every expected beat must have been delivered
    for (int k = 0; k < 4; k++) chk("sb_leftover", k, sb_size(k), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_a_queue.md
TL_A_QUEUE -- requirements
Module: tl_a_queue

Interface
REQ-001 SHALL have parameter DEPTH, 2, entry count; power of two, >= 2.
REQ-002 SHALL have parameter ADDR_W, 33, address field width.
REQ-003 SHALL have parameter DATA_W, 64, data field width.
REQ-004 SHALL have parameter SOURCE_W, 5, source field width.
REQ-005 SHALL have parameter FLOW, 0, 1 = empty-queue combinational bypass enq->deq.
REQ-006 SHALL have parameter PIPE, 0, 1 = enq_ready also asserted when full and io_deq_ready.
REQ-007 SHALL have ports (clock and reset first):
 clock  in  1  sole clock, rising edge.
 reset_n  in  1  asynchronous, active-low reset.
 io_enq_ready  out  1  entry can be accepted.
 io_enq_valid  in  1  producer offers a beat.
 io_enq_bits_opcode/param  in  3/3  TL A opcode/param.
 io_enq_bits_size  in  4  log2 transfer size.
 io_enq_bits_source  in  SOURCE_W  source ID.
 io_enq_bits_address  in  ADDR_W  byte address.
 io_enq_bits_data  in  DATA_W  payload.
 io_enq_bits_corrupt  in  1  corrupt flag (present only with macro, REQ-024).
 io_deq_ready  in  1  consumer accepts.
 io_deq_valid  out  1  head entry valid.
 io_deq_bits_*  out  same widths  head entry fields, incl. corrupt.
 io_count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-008 SHALL transfer enq on clock edge where io_enq_valid & io_enq_ready; deq where io_deq_valid & io_deq_ready.
REQ-009 SHALL store entries in a DEPTH-entry flop array; write pointer, read pointer $clog2(DEPTH) bits, each incrementing modulo DEPTH on its transfer.
REQ-010 SHALL distinguish full/empty on pointer match via maybe_full flag: set on enq-only cycle, cleared on deq-only cycle, held otherwise.
REQ-011 SHALL drive io_deq_bits_* combinationally from array[read pointer]; zero-cycle read latency; enq-to-deq latency 1 cycle when FLOW=0.
REQ-012 SHALL drive io_enq_ready = ~full (PIPE=0) or ~full | io_deq_ready (PIPE=1).
REQ-013 SHALL drive io_deq_valid = ~empty (FLOW=0) or ~empty | io_enq_valid (FLOW=1).
REQ-014 With FLOW=1 and empty: io_deq_bits_* SHALL equal io_enq_bits_*; if io_deq_ready, no write, pointers and count unchanged.
REQ-015 Simultaneous enq and deq, neither empty nor full: both pointers advance, count and maybe_full unchanged.
REQ-016 Full, PIPE=1, io_deq_ready=1, io_enq_valid=1: head leaves, new beat written at old head slot, count stays DEPTH.
REQ-017 io_count SHALL increment on enq-only, decrement on deq-only, hold otherwise; never exceed DEPTH nor underflow.
REQ-018 io_deq_bits_* SHALL hold stable while io_deq_valid & ~io_deq_ready (FLOW bypass excepted).

Reset
REQ-019 reset_n low SHALL asynchronously clear both pointers, maybe_full, count.
REQ-020 During/after reset outputs SHALL be io_enq_ready=1, io_deq_valid=0 (FLOW=1: follows io_enq_valid), io_count=0.
REQ-021 Array contents SHALL NOT be reset; io_deq_bits_* undefined while empty.
REQ-022 Reset asserted mid-operation SHALL discard all entries; first post-reset deq returns first post-reset enq.
REQ-023 Reset deassertion SHALL be synchronised externally; block samples no state change while reset_n low.

Configuration
REQ-024 Macro TL_A_QUEUE_CORRUPT_EN defined: io_enq_bits_corrupt port exists, stored per entry, returned on io_deq_bits_corrupt.
REQ-025 Macro undefined: no io_enq_bits_corrupt port, no corrupt storage, io_deq_bits_corrupt tied 0.

Structure
REQ-026 Shared package tl_pkg SHALL hold TL A opcode enum, size width constant, default ADDR_W/DATA_W/SOURCE_W.
REQ-027 Flop array SHALL be sub-module tl_queue_mem (DEPTH x entry width, 1 write, 1 async read port).

Verification
REQ-028 DEPTH=4: 4 enq (data 0x1..0x4), no deq -> count 4, enq_ready=0; 5th enq refused; 4 deq return 0x1..0x4 in order.
REQ-029 DEPTH=2, FLOW=1, empty, enq_valid+deq_ready, data 0xAB -> deq_valid same cycle, data 0xAB, count stays 0.
REQ-030 DEPTH=2, PIPE=1, full, enq 0xCC with deq_ready -> head deq'd, enq accepted, count 2, next heads old 2nd then 0xCC.
REQ-031 DEPTH=8: 20 continuous simultaneous enq/deq -> pointer wrap twice, in-order data, count constant.
REQ-032 reset_n pulsed low mid-cycle with count 3 -> count 0, deq_valid 0 immediately, enq_ready 1.
REQ-033 Macro on: corrupt=1 enq -> deq corrupt 1; macro off -> deq corrupt always 0.
